// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared state encoding and default widths for the fetch sequencer
package fetch_seq_pkg;
  typedef enum logic [1:0] {BOOT, FETCH, ISSUE, HALTED} state_t;
  localparam int DEF_IADDR_WIDTH = 10;
  localparam int DEF_INSN_WIDTH = 16;
endpackage

// File: rtl/fetch_seq_irq.sv
// fetch_seq_irq: interrupt entry bookkeeping (enable flag, irq_take pulse, return address)
//   retire            : insn retiring this cycle (exec_done while issuing)
//   irq / irq_reti    : interrupt request / return-from-interrupt pulse
//   ip_next           : next IP from datapath, captured as return address on entry
//   enter             : combinational, interrupt is taken at this retire
//   irq_take          : registered one-cycle pulse following entry
//   irq_ret_ip        : return address, valid with irq_take
module fetch_seq_irq import fetch_seq_pkg::*; #(
  parameter int IADDR_WIDTH = DEF_IADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   retire,
  input  logic                   irq,
  input  logic                   irq_reti,
  input  logic [IADDR_WIDTH-1:0] ip_next,
  output logic                   enter,
  output logic                   irq_take,
  output logic [IADDR_WIDTH-1:0] irq_ret_ip
);
  logic en;
  assign enter = retire && irq && en;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      en <= 1'b1;
      irq_take <= 1'b0;
      irq_ret_ip <= '0;
    end else begin
      irq_take <= enter;
      if (enter) irq_ret_ip <= ip_next;
      en <= enter ? 1'b0 : (irq_reti ? 1'b1 : en);
    end
endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch sequencer owning IP, fetching over req/ack and issuing to execute
//   imem_req/imem_addr/imem_ack/imem_data : instruction memory port (req registered, addr = IP)
//   insn_valid/insn/insn_ip               : instruction awaiting execution
//   exec_done/ip_next                     : retire strobe and next IP from datapath
//   halt/halted                           : halt request and halted status
//   irq/irq_reti/irq_take/irq_ret_ip      : interrupt entry, present only with FETCH_SEQ_IRQ_EN
module fetch_seq import fetch_seq_pkg::*; #(
  parameter int IADDR_WIDTH = DEF_IADDR_WIDTH,
  parameter int INSN_WIDTH = DEF_INSN_WIDTH,
  parameter logic [IADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [IADDR_WIDTH-1:0] IRQ_VECTOR = IADDR_WIDTH'(2)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [IADDR_WIDTH-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic [INSN_WIDTH-1:0]  imem_data,
  output logic                   insn_valid,
  output logic [INSN_WIDTH-1:0]  insn,
  output logic [IADDR_WIDTH-1:0] insn_ip,
  input  logic                   exec_done,
  input  logic [IADDR_WIDTH-1:0] ip_next,
  input  logic                   halt,
`ifdef FETCH_SEQ_IRQ_EN
  input  logic                   irq,
  input  logic                   irq_reti,
  output logic                   irq_take,
  output logic [IADDR_WIDTH-1:0] irq_ret_ip,
`endif
  output logic                   halted
);
  state_t state, state_next;
  logic [IADDR_WIDTH-1:0] ip;
  logic retire, take_irq;
  assign retire = state == ISSUE && exec_done;
  assign imem_addr = ip;
`ifdef FETCH_SEQ_IRQ_EN
  fetch_seq_irq #(.IADDR_WIDTH(IADDR_WIDTH)) u_irq (
    .clk(clk), .rst(rst), .retire(retire), .irq(irq), .irq_reti(irq_reti),
    .ip_next(ip_next), .enter(take_irq), .irq_take(irq_take), .irq_ret_ip(irq_ret_ip)
  );
`else
  assign take_irq = 1'b0;
`endif
  always_comb begin
    state_next = state;
    case (state)
      FETCH:   state_next = imem_ack ? ISSUE : FETCH;
      ISSUE:   state_next = exec_done ? (halt ? HALTED : FETCH) : ISSUE;
      default: state_next = halt ? HALTED : FETCH;
    endcase
  end
  // Status outputs are registered from the next state so they change with the state itself.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= BOOT;
      ip <= RESET_VECTOR;
      insn <= '0;
      insn_ip <= RESET_VECTOR;
      imem_req <= 1'b0;
      insn_valid <= 1'b0;
      halted <= 1'b0;
    end else begin
      state <= state_next;
      imem_req <= state_next == FETCH;
      insn_valid <= state_next == ISSUE;
      halted <= state_next == HALTED;
      if (state == FETCH && imem_ack) begin
        insn <= imem_data;
        insn_ip <= ip;
      end
      if (retire) ip <= take_irq ? IRQ_VECTOR : ip_next;
    end
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: table vectors, reset corner cases and a randomized run against a behavioural model
module tb_fetch_seq;
  logic clk = 0, rst = 1;
  logic imem_req, imem_ack = 0, insn_valid, exec_done = 0, halt = 0, halted;
  logic [9:0] imem_addr, insn_ip, ip_next = 0;
  logic [15:0] imem_data = 0, insn;
`ifdef FETCH_SEQ_IRQ_EN
  logic irq = 0, irq_reti = 0, irq_take;
  logic [9:0] irq_ret_ip;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fetch_seq dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .insn_valid(insn_valid), .insn(insn), .insn_ip(insn_ip),
    .exec_done(exec_done), .ip_next(ip_next), .halt(halt),
`ifdef FETCH_SEQ_IRQ_EN
    .irq(irq), .irq_reti(irq_reti), .irq_take(irq_take), .irq_ret_ip(irq_ret_ip),
`endif
    .halted(halted)
  );
  typedef struct {
    logic ack; logic [15:0] data; logic done; logic [9:0] ipn; logic hlt_in;
    logic req; logic [9:0] addr; logic valid; logic [15:0] insn; logic [9:0] iip; logic hlt;
  } vec_t;
  vec_t tv[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] outs();
    return {25'd0, imem_req, imem_addr, insn_valid, insn, insn_ip, halted};
  endfunction
  function automatic logic [63:0] pack(logic r, logic [9:0] a, logic v, logic [15:0] i, logic [9:0] p, logic h);
    return {25'd0, r, a, v, i, p, h};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    imem_ack = 0; exec_done = 0; halt = 0; ip_next = 0; imem_data = 0;
    rst = 1;
    step();
    step();
    rst = 0;
  endtask
  bit m_boot, m_req, m_valid, m_halt;
  logic [9:0] m_ip, m_iip;
  logic [15:0] m_insn;
  initial begin
    tv.push_back(vec_t'{0, 16'h0000, 0, 10'h000, 0, 0, 10'h000, 0, 16'h0000, 10'h000, 0});
    tv.push_back(vec_t'{1, 16'hA000, 0, 10'h000, 0, 1, 10'h000, 0, 16'h0000, 10'h000, 0});
    tv.push_back(vec_t'{0, 16'h0000, 1, 10'h001, 0, 0, 10'h000, 1, 16'hA000, 10'h000, 0});
    tv.push_back(vec_t'{1, 16'hA001, 0, 10'h000, 0, 1, 10'h001, 0, 16'hA000, 10'h000, 0});
    tv.push_back(vec_t'{0, 16'h0000, 1, 10'h002, 0, 0, 10'h001, 1, 16'hA001, 10'h001, 0});
    tv.push_back(vec_t'{1, 16'hA002, 0, 10'h000, 0, 1, 10'h002, 0, 16'hA001, 10'h001, 0});
    tv.push_back(vec_t'{0, 16'h0000, 1, 10'h005, 0, 0, 10'h002, 1, 16'hA002, 10'h002, 0});
    tv.push_back(vec_t'{0, 16'hDEAD, 0, 10'h000, 0, 1, 10'h005, 0, 16'hA002, 10'h002, 0});
    tv.push_back(vec_t'{0, 16'hDEAD, 1, 10'h111, 0, 1, 10'h005, 0, 16'hA002, 10'h002, 0});
    tv.push_back(vec_t'{0, 16'hDEAD, 0, 10'h000, 0, 1, 10'h005, 0, 16'hA002, 10'h002, 0});
    tv.push_back(vec_t'{1, 16'hB005, 0, 10'h000, 0, 1, 10'h005, 0, 16'hA002, 10'h002, 0});
    tv.push_back(vec_t'{0, 16'h0000, 0, 10'h000, 0, 0, 10'h005, 1, 16'hB005, 10'h005, 0});
    tv.push_back(vec_t'{0, 16'h0000, 1, 10'h3FF, 0, 0, 10'h005, 1, 16'hB005, 10'h005, 0});
    tv.push_back(vec_t'{1, 16'hC3FF, 0, 10'h000, 0, 1, 10'h3FF, 0, 16'hB005, 10'h005, 0});
    tv.push_back(vec_t'{0, 16'h0000, 1, 10'h000, 0, 0, 10'h3FF, 1, 16'hC3FF, 10'h3FF, 0});
    tv.push_back(vec_t'{0, 16'h0000, 0, 10'h000, 1, 1, 10'h000, 0, 16'hC3FF, 10'h3FF, 0});
    tv.push_back(vec_t'{1, 16'hD000, 0, 10'h000, 1, 1, 10'h000, 0, 16'hC3FF, 10'h3FF, 0});
    tv.push_back(vec_t'{0, 16'h0000, 1, 10'h009, 1, 0, 10'h000, 1, 16'hD000, 10'h000, 0});
    tv.push_back(vec_t'{1, 16'hFFFF, 0, 10'h000, 1, 0, 10'h009, 0, 16'hD000, 10'h000, 1});
    tv.push_back(vec_t'{0, 16'h0000, 0, 10'h000, 0, 0, 10'h009, 0, 16'hD000, 10'h000, 1});
    tv.push_back(vec_t'{1, 16'hE009, 0, 10'h000, 0, 1, 10'h009, 0, 16'hD000, 10'h000, 0});
    tv.push_back(vec_t'{1, 16'hFFFF, 0, 10'h000, 0, 0, 10'h009, 1, 16'hE009, 10'h009, 0});
    tv.push_back(vec_t'{0, 16'h0000, 0, 10'h000, 0, 0, 10'h009, 1, 16'hE009, 10'h009, 0});
    do_reset();
    for (int i = 0; i < tv.size(); i++) begin
      chk($sformatf("vec%0d", i), outs(), pack(tv[i].req, tv[i].addr, tv[i].valid, tv[i].insn, tv[i].iip, tv[i].hlt));
      imem_ack = tv[i].ack; imem_data = tv[i].data; exec_done = tv[i].done;
      ip_next = tv[i].ipn; halt = tv[i].hlt_in;
      step();
    end
    // still in ISSUE here: async reset must clear outputs without a clock edge
    imem_ack = 0; exec_done = 0; halt = 0;
    #2 rst = 1;
    #1 chk("async_rst", outs(), pack(0, 10'h000, 0, 16'h0000, 10'h000, 0));
    step();
    rst = 0;
    chk("rst_boot", outs(), pack(0, 10'h000, 0, 16'h0000, 10'h000, 0));
    imem_ack = 1; imem_data = 16'h1234;
    step();
    chk("stray_ack", outs(), pack(1, 10'h000, 0, 16'h0000, 10'h000, 0));
    imem_ack = 0;
    step();
    chk("stray_ack_hold", outs(), pack(1, 10'h000, 0, 16'h0000, 10'h000, 0));
    do_reset();
    m_boot = 1; m_req = 0; m_valid = 0; m_halt = 0; m_ip = 0; m_iip = 0; m_insn = 0;
    for (int n = 0; n < 3000; n++) begin
      chk("rand", outs(), pack(m_req, m_ip, m_valid, m_insn, m_iip, m_halt));
      if (imem_req && insn_valid) chk("req_valid_excl", {63'd0, imem_req & insn_valid}, 64'd0);
      imem_ack = $urandom_range(0, 1); exec_done = $urandom_range(0, 1);
      halt = $urandom_range(0, 4) == 0; ip_next = 10'($urandom); imem_data = 16'($urandom);
      @(posedge clk);
      if (m_boot) begin
        m_boot = 0; m_halt = halt; m_req = !halt;
      end else if (m_req) begin
        if (imem_ack) begin m_insn = imem_data; m_iip = m_ip; m_req = 0; m_valid = 1; end
      end else if (m_valid) begin
        if (exec_done) begin m_ip = ip_next; m_valid = 0; m_halt = halt; m_req = !halt; end
      end else if (m_halt && !halt) begin
        m_halt = 0; m_req = 1;
      end
      #1;
    end
`ifdef FETCH_SEQ_IRQ_EN
    do_reset();
    imem_ack = 1;
    step();
    step();
    imem_ack = 0; exec_done = 1; irq = 1; ip_next = 10'd7;
    step();
    chk("irq_take", {63'd0, irq_take}, 64'd1);
    chk("irq_ret_ip", {54'd0, irq_ret_ip}, 64'd7);
    chk("irq_vector", {54'd0, imem_addr}, 64'd2);
    irq = 0; exec_done = 0; imem_ack = 1;
    step();
    chk("irq_pulse", {63'd0, irq_take}, 64'd0);
    imem_ack = 0; exec_done = 1; irq = 1; ip_next = 10'd4;
    step();
    chk("irq_masked", {54'd0, imem_addr, irq_take}, {53'd0, 10'd4, 1'b0});
    irq = 0; exec_done = 0; irq_reti = 1; imem_ack = 1;
    step();
    irq_reti = 0; imem_ack = 0; exec_done = 1; irq = 1; ip_next = 10'd6;
    step();
    chk("irq_reenabled", {54'd0, imem_addr, irq_take}, {53'd0, 10'd2, 1'b1});
    chk("irq_ret_ip2", {54'd0, irq_ret_ip}, 64'd6);
    irq = 0; exec_done = 0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
